key_mode_selector: RTL

//  Input-side counterpart of the LED pattern drivers: turns a raw push-button into a registered mode index

---
 rtl/key_mode_selector.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/key_mode_selector.sv
// Push-button to LED mode index: 2-flop sync, debounce, short/long press FSM.
// Define KEY_PREV_EN to add a second key (key_prev_n) that steps the mode backwards.

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic held
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          key_s;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= raw_n;
      sync_p1 <= sync_p0;
    end
  end

  assign key_s = ~sync_p1;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= 1'b0;
      cnt  <= '0;
    end else if (key_s != held) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        held <= ~held;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end
endmodule

module key_mode_selector #(
  parameter int DEBOUNCE_CYCLES   = 20,
  parameter int LONG_PRESS_CYCLES = 2400,
  parameter int NUM_MODES         = 5,
  parameter int MODE_W            = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_n,
`ifdef KEY_PREV_EN
  input  logic              key_prev_n,
`endif
  output logic [MODE_W-1:0] mode,
  output logic              mode_change,
  output logic              key_held
);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

  state_t            state, state_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic [MODE_W-1:0] mode_nxt;
  logic              change_nxt;
  logic              owner_held;

  function automatic logic [MODE_W-1:0] step_up(input logic [MODE_W-1:0] m);
    return (m == MODE_W'(NUM_MODES - 1)) ? '0 : m + 1'b1;
  endfunction

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .rst_n(rst_n), .raw_n(key_n), .held(key_held)
  );

`ifdef KEY_PREV_EN
  logic key_prev_held;
  logic owner_prev, owner_nxt;

  function automatic logic [MODE_W-1:0] step_down(input logic [MODE_W-1:0] m);
    return (m == '0) ? MODE_W'(NUM_MODES - 1) : m - 1'b1;
  endfunction

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clk(clk), .rst_n(rst_n), .raw_n(key_prev_n), .held(key_prev_held)
  );

  // The key that opened the press owns it until the FSM is back in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) owner_prev <= 1'b0;
    else        owner_prev <= owner_nxt;
  end

  assign owner_held = owner_prev ? key_prev_held : key_held;
`else
  assign owner_held = key_held;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      mode        <= '0;
      mode_change <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      mode        <= mode_nxt;
      mode_change <= change_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    mode_nxt   = mode;
    change_nxt = 1'b0;
`ifdef KEY_PREV_EN
    owner_nxt  = owner_prev;
`endif
    case (state)
      IDLE: begin
        if (key_held) begin
          state_nxt = PRESSED;
          hold_nxt  = '0;
`ifdef KEY_PREV_EN
          owner_nxt = 1'b0;
        end else if (key_prev_held) begin
          state_nxt = PRESSED;
          hold_nxt  = '0;
          owner_nxt = 1'b1;
`endif
        end
      end
      PRESSED: begin
        if (!owner_held) begin
          state_nxt  = IDLE;
          change_nxt = 1'b1;
`ifdef KEY_PREV_EN
          mode_nxt   = owner_prev ? step_down(mode) : step_up(mode);
`else
          mode_nxt   = step_up(mode);
`endif
        end else if (hold_cnt == HW'(LONG_PRESS_CYCLES - 1)) begin
          // Pulse even if already at mode 0 so consumers restart their pattern.
          state_nxt  = LONG;
          mode_nxt   = '0;
          change_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      LONG: begin
        if (!owner_held) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
